// File: rtl/inst_queue.sv
// Instruction queue between fetcher and decoder: in-order circular buffer of PC/inst/opType/pred.
// Latency: push visible at head one cycle later (no bypass); stall raised at DEPTH-1 to absorb one in-flight push.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int OP_W   = 7
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     clr_in,
    input  logic                     if_to_iq_ready,
    input  logic [ADDR_W-1:0]        if_to_iq_PC,
    input  logic [INST_W-1:0]        if_to_iq_inst,
    input  logic [OP_W-1:0]          if_to_iq_opType,
    input  logic                     if_to_iq_pred_br,
    output logic                     iq_to_if_stall,
    input  logic                     dc_to_iq_ready,
    output logic                     iq_to_dc_valid,
    output logic [ADDR_W-1:0]        iq_to_dc_PC,
    output logic [INST_W-1:0]        iq_to_dc_inst,
    output logic [OP_W-1:0]          iq_to_dc_opType,
    output logic                     iq_to_dc_pred_br,
    output logic [$clog2(DEPTH):0]   iq_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMOST = CNT_W'(DEPTH - 1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [OP_W-1:0]   op_mem   [DEPTH];
    logic              br_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_err_q, overflow_err_d;

    logic push, pop, drop, wr_en;

    always_comb begin
        pop  = dc_to_iq_ready & iq_to_dc_valid;
        push = if_to_iq_ready & ((count_q < FULL) | pop);
        drop = if_to_iq_ready & (count_q >= FULL) & ~pop;

        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        overflow_err_d = overflow_err_q;
        wr_en          = 1'b0;

        if (rdy_in) begin
            if (clr_in) begin
                // Flush wins over any simultaneous push/pop.
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                wr_en = push;
                if (push) tail_d = tail_q + PTR_W'(1);
                if (pop)  head_d = head_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
                if (drop) overflow_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            pc_mem[tail_q]   <= if_to_iq_PC;
            inst_mem[tail_q] <= if_to_iq_inst;
            op_mem[tail_q]   <= if_to_iq_opType;
            br_mem[tail_q]   <= if_to_iq_pred_br;
        end
    end

    always_comb begin
        iq_to_dc_valid   = (count_q != '0);
        iq_to_if_stall   = (count_q >= ALMOST);
        iq_count         = count_q;
        iq_to_dc_PC      = iq_to_dc_valid ? pc_mem[head_q]   : '0;
        iq_to_dc_inst    = iq_to_dc_valid ? inst_mem[head_q] : '0;
        iq_to_dc_opType  = iq_to_dc_valid ? op_mem[head_q]   : '0;
        iq_to_dc_pred_br = iq_to_dc_valid ? br_mem[head_q]   : 1'b0;
    end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: latency, fill/stall/overflow, wrap, flush, freeze, async reset.
module tb_inst_queue;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clr_in;
    logic        if_to_iq_ready;
    logic [31:0] if_to_iq_PC;
    logic [31:0] if_to_iq_inst;
    logic [6:0]  if_to_iq_opType;
    logic        if_to_iq_pred_br;
    logic        iq_to_if_stall;
    logic        dc_to_iq_ready;
    logic        iq_to_dc_valid;
    logic [31:0] iq_to_dc_PC;
    logic [31:0] iq_to_dc_inst;
    logic [6:0]  iq_to_dc_opType;
    logic        iq_to_dc_pred_br;
    logic [4:0]  iq_count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_queue dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .rdy_in           (rdy_in),
        .clr_in           (clr_in),
        .if_to_iq_ready   (if_to_iq_ready),
        .if_to_iq_PC      (if_to_iq_PC),
        .if_to_iq_inst    (if_to_iq_inst),
        .if_to_iq_opType  (if_to_iq_opType),
        .if_to_iq_pred_br (if_to_iq_pred_br),
        .iq_to_if_stall   (iq_to_if_stall),
        .dc_to_iq_ready   (dc_to_iq_ready),
        .iq_to_dc_valid   (iq_to_dc_valid),
        .iq_to_dc_PC      (iq_to_dc_PC),
        .iq_to_dc_inst    (iq_to_dc_inst),
        .iq_to_dc_opType  (iq_to_dc_opType),
        .iq_to_dc_pred_br (iq_to_dc_pred_br),
        .iq_count         (iq_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [6:0] op, input logic br);
        if_to_iq_ready   = 1'b1;
        if_to_iq_PC      = pc;
        if_to_iq_inst    = inst;
        if_to_iq_opType  = op;
        if_to_iq_pred_br = br;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        if_to_iq_ready = 1'b0; if_to_iq_PC = '0; if_to_iq_inst = '0;
        if_to_iq_opType = '0; if_to_iq_pred_br = 1'b0; dc_to_iq_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_count", 32'(iq_count), 0);
        chk("rst_valid", 32'(iq_to_dc_valid), 0);
        chk("rst_stall", 32'(iq_to_if_stall), 0);
        chk("rst_pc",    iq_to_dc_PC, 0);
        chk("rst_inst",  iq_to_dc_inst, 0);
        rst_n_in = 1'b1;
        tick();

        // 1: single push, one-cycle latency, then pop
        drive_push(32'h0, 32'h0000_0013, 7'h13, 1'b1);
        #1;
        chk("t1_nobypass", 32'(iq_to_dc_valid), 0);
        tick();
        if_to_iq_ready = 1'b0;
        chk("t1_valid", 32'(iq_to_dc_valid), 1);
        chk("t1_pc",    iq_to_dc_PC, 32'h0);
        chk("t1_inst",  iq_to_dc_inst, 32'h13);
        chk("t1_op",    32'(iq_to_dc_opType), 32'h13);
        chk("t1_br",    32'(iq_to_dc_pred_br), 1);
        chk("t1_count", 32'(iq_count), 1);
        dc_to_iq_ready = 1'b1;
        tick();
        dc_to_iq_ready = 1'b0;
        chk("t1_pop_valid", 32'(iq_to_dc_valid), 0);
        chk("t1_pop_count", 32'(iq_count), 0);
        chk("t1_pop_pc0",   iq_to_dc_PC, 0);

        // 2: fill with decoder stalled
        for (int i = 0; i < 15; i++) begin
            drive_push(32'(i * 4), 32'h1000 + 32'(i), 7'(i), i[0]);
            tick();
            if (i == 13) chk("t2_stall_at14", 32'(iq_to_if_stall), 0);
        end
        chk("t2_count15", 32'(iq_count), 15);
        chk("t2_stall15", 32'(iq_to_if_stall), 1);
        drive_push(32'h3c, 32'h100f, 7'h0f, 1'b1);
        tick();
        chk("t2_count16", 32'(iq_count), 16);
        chk("t2_ovf_clear", 32'(dut.overflow_err_q), 0);
        drive_push(32'h99, 32'hdead, 7'h7f, 1'b1);
        tick();
        chk("t2_count_drop", 32'(iq_count), 16);
        chk("t2_ovf_set", 32'(dut.overflow_err_q), 1);
        chk("t2_head_pc", iq_to_dc_PC, 32'h0);
        chk("t2_head_inst", iq_to_dc_inst, 32'h1000);

        // 3: push+pop at full, then drain in order across wrap
        drive_push(32'h40, 32'h1010, 7'h10, 1'b0);
        dc_to_iq_ready = 1'b1;
        tick();
        if_to_iq_ready = 1'b0;
        chk("t3_count_full", 32'(iq_count), 16);
        for (int k = 1; k <= 16; k++) begin
            chk("t3_order", iq_to_dc_PC, 32'(k * 4));
            tick();
        end
        dc_to_iq_ready = 1'b0;
        chk("t3_drained", 32'(iq_count), 0);

        // 4: flush at count 5 with push active
        for (int i = 0; i < 5; i++) begin
            drive_push(32'h100 + 32'(i * 4), 32'h13, 7'h13, 1'b0);
            tick();
        end
        chk("t4_count5", 32'(iq_count), 5);
        drive_push(32'h200, 32'h13, 7'h13, 1'b0);
        dc_to_iq_ready = 1'b1;
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        dc_to_iq_ready = 1'b0;
        if_to_iq_ready = 1'b0;
        chk("t4_clr_count", 32'(iq_count), 0);
        chk("t4_clr_valid", 32'(iq_to_dc_valid), 0);
        chk("t4_clr_stall", 32'(iq_to_if_stall), 0);
        drive_push(32'h300, 32'h0000_0093, 7'h13, 1'b0);
        tick();
        chk("t4_after_pc", iq_to_dc_PC, 32'h300);
        chk("t4_after_count", 32'(iq_count), 1);

        // 5: freeze with rdy_in low
        drive_push(32'h304, 32'h13, 7'h13, 1'b0);
        tick();
        drive_push(32'h308, 32'h13, 7'h13, 1'b0);
        tick();
        chk("t5_count3", 32'(iq_count), 3);
        rdy_in = 1'b0;
        drive_push(32'h500, 32'h13, 7'h13, 1'b1);
        dc_to_iq_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_hold_count", 32'(iq_count), 3);
            chk("t5_hold_pc", iq_to_dc_PC, 32'h300);
            chk("t5_hold_stall", 32'(iq_to_if_stall), 0);
        end
        rdy_in = 1'b1;
        dc_to_iq_ready = 1'b0;
        if_to_iq_ready = 1'b0;
        tick();
        chk("t5_resume", 32'(iq_count), 3);

        // 6: async reset between edges at count 7
        for (int i = 0; i < 4; i++) begin
            drive_push(32'h600 + 32'(i * 4), 32'h13, 7'h13, 1'b1);
            tick();
        end
        if_to_iq_ready = 1'b0;
        chk("t6_count7", 32'(iq_count), 7);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t6_arst_count", 32'(iq_count), 0);
        chk("t6_arst_valid", 32'(iq_to_dc_valid), 0);
        chk("t6_arst_pc",    iq_to_dc_PC, 0);
        chk("t6_arst_br",    32'(iq_to_dc_pred_br), 0);
        chk("t6_arst_ovf",   32'(dut.overflow_err_q), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
